// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor.
// Holds the FSM state type, the flag-bit positions and width-generic IEEE helpers.
// The helpers work on a 64-bit carrier so they serve any EXP_W/MAN_W that fits in it.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_e;

   // Bit positions inside flags = {invalid, overflow, inexact}
   localparam int FLAG_INVALID  = 2;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INEXACT  = 0;

   function automatic logic fp_sign(input logic [63:0] w, input int ew, input int mw);
      return w[ew+mw];
   endfunction

   function automatic logic [63:0] fp_exp(input logic [63:0] w, input int ew, input int mw);
      return (w >> mw) & ((64'd1 << ew) - 64'd1);
   endfunction

   function automatic logic [63:0] fp_man(input logic [63:0] w, input int mw);
      return w & ((64'd1 << mw) - 64'd1);
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, only the top fraction bit set
   function automatic logic [63:0] fp_qnan(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational classifier for one IEEE operand.
// Ports: word_i (packed operand) -> sign_o, is_nan_o, is_inf_o, is_zero_o, is_sub_o,
//        hidden_o (implicit leading bit), eff_exp_o (subnormals read as exponent 1), frac_o.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic [W-1:0]     word_i,
   output logic             sign_o,
   output logic             is_nan_o,
   output logic             is_inf_o,
   output logic             is_zero_o,
   output logic             is_sub_o,
   output logic             hidden_o,
   output logic [EXP_W-1:0] eff_exp_o,
   output logic [MAN_W-1:0] frac_o
);

   logic [EXP_W-1:0] exp_f;
   logic             exp_max;
   logic             exp_min;
   logic             frac_nz;

   assign exp_f   = EXP_W'(fp_exp(64'(word_i), EXP_W, MAN_W));
   assign frac_o  = MAN_W'(fp_man(64'(word_i), MAN_W));
   assign sign_o  = fp_sign(64'(word_i), EXP_W, MAN_W);

   assign exp_max = &exp_f;
   assign exp_min = ~|exp_f;
   assign frac_nz = |frac_o;

   assign is_nan_o  = exp_max & frac_nz;
   assign is_inf_o  = exp_max & ~frac_nz;
   assign is_zero_o = exp_min & ~frac_nz;
   assign is_sub_o  = exp_min & frac_nz;
   assign hidden_o  = ~exp_min;
   // Subnormals share the scale of exponent 1; only the hidden bit differs
   assign eff_exp_o = exp_min ? EXP_W'(1) : exp_f;

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract with RNE rounding, subnormals and exception flags.
// Ports: clk, rst_n; in_valid/in_ready + op_sub, a, b (operand side);
//        out_valid/out_ready + result, flags {invalid, overflow, inexact} (result side).
module fp_addsub_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [2:0]   flags
);

   // Datapath mantissa: hidden, fraction, guard, round, sticky
   localparam int MW  = MAN_W + 4;
   localparam int EW2 = EXP_W + 2;
   localparam logic [W-1:0]           QNAN     = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic signed [EW2-1:0]  E_ONE    = EW2'(1);
   localparam logic signed [EW2-1:0]  E_MAX    = EW2'((1 << EXP_W) - 1);
   localparam logic signed [EW2-1:0]  COLLAPSE = EW2'(MAN_W + 3);

   state_e                state_q;
   logic [W-1:0]          a_q, b_q, result_q;
   logic [2:0]            flags_q;
   logic                  in_ready_q, out_valid_q;
   logic                  sx_q, sy_q, s_q;
   logic signed [EW2-1:0] ex_q, ey_q, e_q;
   logic [MW-1:0]         mx_q, my_q;
   logic [MW:0]           m_q;

   // Operand classification
   logic             ua_s, ua_nan, ua_inf, ua_zero, ua_sub, ua_hid;
   logic             ub_s, ub_nan, ub_inf, ub_zero, ub_sub, ub_hid;
   logic [EXP_W-1:0] ua_exp, ub_exp;
   logic [MAN_W-1:0] ua_frac, ub_frac;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .word_i(a_q), .sign_o(ua_s), .is_nan_o(ua_nan), .is_inf_o(ua_inf), .is_zero_o(ua_zero),
      .is_sub_o(ua_sub), .hidden_o(ua_hid), .eff_exp_o(ua_exp), .frac_o(ua_frac));

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .word_i(b_q), .sign_o(ub_s), .is_nan_o(ub_nan), .is_inf_o(ub_inf), .is_zero_o(ub_zero),
      .is_sub_o(ub_sub), .hidden_o(ub_hid), .eff_exp_o(ub_exp), .frac_o(ub_frac));

   logic          spec_hit, spec_inv, swap;
   logic [W-1:0]  spec_res;
   logic [MW-1:0] ma, mb;
   logic signed [EW2-1:0] diff;

   // Special operands bypass the arithmetic path entirely
   always_comb begin
      spec_hit = ua_nan | ub_nan | ua_inf | ub_inf | ua_zero | ub_zero;
      spec_res = '0;
      spec_inv = 1'b0;
      if (ua_nan | ub_nan) begin
         spec_res = QNAN;
      end else if (ua_inf & ub_inf) begin
         spec_res = (ua_s != ub_s) ? QNAN : a_q;
         spec_inv = (ua_s != ub_s);
      end else if (ua_inf) begin
         spec_res = a_q;
      end else if (ub_inf) begin
         spec_res = b_q;
      end else if (ua_zero & ub_zero) begin
         spec_res = {ua_s & ub_s, {(W-1){1'b0}}};
      end else if (ua_zero) begin
         spec_res = b_q;
      end else begin
         spec_res = a_q;
      end
   end

   // Hidden bit is redundant with is_sub for finite non-zero operands; both gate it for clarity
   assign ma   = {ua_hid & ~ua_sub, ua_frac, 3'b000};
   assign mb   = {ub_hid & ~ub_sub, ub_frac, 3'b000};
   assign swap = ub_exp > ua_exp;
   assign diff = ex_q - ey_q;

   logic [MW:0] add_sum;
   logic        add_sign, add_zero;

   always_comb begin
      add_sign = sx_q;
      if (sx_q == sy_q) begin
         add_sum = {1'b0, mx_q} + {1'b0, my_q};
      end else if (mx_q >= my_q) begin
         add_sum = {1'b0, mx_q - my_q};
      end else begin
         add_sum  = {1'b0, my_q - mx_q};
         add_sign = sy_q;
      end
      add_zero = (add_sum == '0);
   end

   logic                  rnd_inc, rnd_inexact;
   logic [MAN_W+1:0]      rnd_sum;
   logic signed [EW2-1:0] rnd_e;
   logic [W-1:0]          rnd_res;
   logic [2:0]            rnd_flags;

   always_comb begin
      rnd_inexact = m_q[2] | m_q[1] | m_q[0];
      rnd_inc     = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
      rnd_sum     = {1'b0, m_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
      // Mantissa carry leaves a zero fraction, so only the exponent needs bumping
      rnd_e       = e_q + {{(EW2-1){1'b0}}, rnd_sum[MAN_W+1]};
      rnd_flags   = '0;
      rnd_flags[FLAG_INEXACT] = rnd_inexact;
      if (rnd_e >= E_MAX) begin
         rnd_res = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flags[FLAG_OVERFLOW] = 1'b1;
         rnd_flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         // No leading one after rounding means the value is subnormal: stored exponent 0
         rnd_res = {s_q,
                    (rnd_sum[MAN_W+1] | rnd_sum[MAN_W]) ? rnd_e[EXP_W-1:0] : {EXP_W{1'b0}},
                    rnd_sum[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         s_q         <= 1'b0;
         ex_q        <= '0;
         ey_q        <= '0;
         e_q         <= '0;
         mx_q        <= '0;
         my_q        <= '0;
         m_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= {b[W-1] ^ op_sub, b[W-2:0]};
                  in_ready_q <= 1'b0;
                  state_q    <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (spec_hit) begin
                  result_q    <= spec_res;
                  flags_q     <= {spec_inv, 2'b00};
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  // x always holds the larger exponent so only y is ever shifted
                  sx_q    <= swap ? ub_s : ua_s;
                  sy_q    <= swap ? ua_s : ub_s;
                  ex_q    <= EW2'(swap ? ub_exp : ua_exp);
                  ey_q    <= EW2'(swap ? ua_exp : ub_exp);
                  mx_q    <= swap ? mb : ma;
                  my_q    <= swap ? ma : mb;
                  state_q <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (diff == '0) begin
                  state_q <= S_ADD;
               end else if (diff > COLLAPSE) begin
                  my_q <= {{(MW-1){1'b0}}, |my_q};
                  ey_q <= ex_q;
               end else begin
                  my_q <= {1'b0, my_q[MW-1:2], |my_q[1:0]};
                  ey_q <= ey_q + E_ONE;
               end
            end
            S_ADD: begin
               if (add_zero) begin
                  result_q    <= '0;
                  flags_q     <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  m_q     <= add_sum;
                  s_q     <= add_sign;
                  e_q     <= ex_q;
                  state_q <= S_NORM;
               end
            end
            S_NORM: begin
               if (m_q[MW]) begin
                  m_q     <= {1'b0, m_q[MW:2], |m_q[1:0]};
                  e_q     <= e_q + E_ONE;
                  state_q <= S_ROUND;
               end else if (!m_q[MW-1] && (e_q > E_ONE)) begin
                  m_q <= {m_q[MW-1:0], 1'b0};
                  e_q <= e_q - E_ONE;
               end else begin
                  state_q <= S_ROUND;
               end
            end
            S_ROUND: begin
               result_q    <= rnd_res;
               flags_q     <= rnd_flags;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: single-precision vector table through a scoreboard,
// back-pressure, latency and reset-abort sequences, plus a half-precision instance.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [2:0]  flags;

   logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_result;
   logic [2:0]  h_flags;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags));

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .op_sub(h_op_sub),
      .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
      .flags(h_flags));

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        op;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   exp_t  sb_q[$];
   exp_t  mon_e;
   vec_t  vt[18];
   int    n_cmp  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out, got no response, expected one", name);
   endtask

   // Results are compared in order when the consumer actually takes them
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", result);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", 64'(result), 64'(mon_e.res));
            check("flags", 64'(flags), 64'(mon_e.flg));
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge
   task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                       input logic push, input exp_t e);
      int w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         fail_timeout("in_ready_wait");
         return;
      end
      in_valid = 1'b1;
      a = va;
      b = vb;
      op_sub = vop;
      if (push) sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Operands must already be captured; scribble over them
      a = $urandom;
      b = $urandom;
      op_sub = 1'($urandom);
   endtask

   task automatic drain();
      int w = 0;
      while (sb_q.size() != 0 && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb_q.size() != 0) begin
         fail_timeout("drain");
         sb_q.delete();
      end
   endtask

   task automatic hsend(input string nm, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] er, input logic [2:0] ef);
      int w = 0;
      while (!h_in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      h_in_valid = 1'b1;
      h_a = va;
      h_b = vb;
      h_op_sub = 1'b0;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      h_a = 16'hFFFF;
      w = 0;
      while (!h_out_valid && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (!h_out_valid) begin
         fail_timeout(nm);
      end else begin
         check(nm, 64'(h_result), 64'(er));
         check({nm, "_flags"}, 64'(h_flags), 64'(ef));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int changes;
      logic [31:0] held;

      vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
      vt[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
      vt[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
      vt[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
      vt[4]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
      vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
      vt[6]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
      vt[7]  = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000};
      vt[8]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b001};
      vt[9]  = '{32'h4B800000, 32'h00000001, 1'b0, 32'h4B800000, 3'b001};
      vt[10] = '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000};
      vt[11] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
      vt[12] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
      vt[13] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 3'b000};
      vt[14] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};
      vt[15] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000};
      vt[16] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
      vt[17] = '{32'h3FFFFFFF, 32'h3F800000, 1'b0, 32'h40400000, 3'b001};

      rst_n = 1'b0;
      in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      h_in_valid = 1'b0; h_op_sub = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_result", 64'(result), 64'(0));
      check("reset_flags", 64'(flags), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         send(vt[i].va, vt[i].vb, vt[i].op, 1'b1, '{vt[i].res, vt[i].flg});
      end
      drain();

      // Special operand: result within two cycles of acceptance
      send(32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, '{32'h7FC00000, 3'b000});
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("special_latency_le2", 64'(lat <= 2), 64'(1));
      drain();

      // Long cancellation path stays inside the finite latency bound
      send(32'h3F800001, 32'h3F800000, 1'b1, 1'b1, '{32'h34000000, 3'b000});
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("finite_latency_le56", 64'(lat <= 56), 64'(1));
      drain();

      // Back-pressure: result held, no new operand accepted
      out_ready = 1'b0;
      send(32'h3F800000, 32'h40000000, 1'b0, 1'b1, '{32'h40400000, 3'b000});
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) fail_timeout("bp_out_valid");
      held = result;
      changes = 0;
      in_valid = 1'b1;
      a = 32'h12345678;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) changes++;
      end
      in_valid = 1'b0;
      check("bp_changes", 64'(changes), 64'(0));
      check("bp_result_held", 64'(result), 64'(32'h40400000));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      drain();

      // Asynchronous reset in the middle of a long alignment
      send(32'h4B000000, 32'h3F800000, 1'b0, 1'b0, '{32'h0, 3'b000});
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_align_out_valid", 64'(out_valid), 64'(0));
      check("rst_mid_align_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(32'h3F800000, 32'h40000000, 1'b0, 1'b1, '{32'h40400000, 3'b000});
      drain();

      // Half-precision instance
      hsend("half_1p1", 16'h3C00, 16'h3C00, 16'h4000, 3'b000);
      hsend("half_ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011);
      hsend("half_inf_nan", 16'h7C00, 16'hFC00, 16'h7E00, 3'b100);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
